// File: rtl/mem_line_port.sv
// Main-memory line port behind the data cache: whole-line refill reads and
// dirty-line writebacks with a fixed access latency and a one-word-per-cycle burst.
module mem_line_port #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 12,
  parameter int unsigned LATENCY       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req,
  input  logic                                   we,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]      line_addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]       wr_line,
  output logic                                   gnt,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]       rd_line,
  output logic                                   busy,
  output logic [31:0]                            rd_count,
  output logic [31:0]                            wr_count
);

  localparam int unsigned LINE_SIZE = 2**LINE_ADDR_LEN;
  localparam int unsigned LA_W      = ADDR_LEN - LINE_ADDR_LEN;
  localparam int unsigned LINE_W    = 32 * LINE_SIZE;
  localparam int unsigned DEPTH     = 2**ADDR_LEN;
  localparam int unsigned CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [LINE_ADDR_LEN-1:0] word_idx_q, word_idx_d;
  logic                     we_q, we_d;
  logic [LA_W-1:0]          line_addr_q, line_addr_d;
  logic [LINE_W-1:0]        wr_line_q, wr_line_d;
  logic [LINE_W-1:0]        rd_line_q, rd_line_d;
  logic                     gnt_q, gnt_d;
  logic                     busy_q, busy_d;
  logic [31:0]              rd_count_q, rd_count_d;
  logic [31:0]              wr_count_q, wr_count_d;

  logic [31:0]              mem [DEPTH];
  logic [ADDR_LEN-1:0]      mem_addr_c;

  assign mem_addr_c = {line_addr_q, word_idx_q};

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    word_idx_d  = word_idx_q;
    we_d        = we_q;
    line_addr_d = line_addr_q;
    wr_line_d   = wr_line_q;
    rd_line_d   = rd_line_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    gnt_d       = 1'b0;
    busy_d      = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = req;
        if (req) begin
          we_d        = we;
          line_addr_d = line_addr;
          wr_line_d   = wr_line;
          wait_cnt_d  = '0;
          word_idx_d  = '0;
          state_d     = (LATENCY > 0) ? WAIT : XFER;
        end
      end
      WAIT: begin
        if (wait_cnt_q == CNT_W'(LATENCY - 1)) state_d = XFER;
        else wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
      XFER: begin
        if (!we_q) rd_line_d[32*int'(word_idx_q) +: 32] = mem[mem_addr_c];
        word_idx_d = word_idx_q + LINE_ADDR_LEN'(1);
        if (word_idx_q == LINE_ADDR_LEN'(LINE_SIZE - 1)) state_d = DONE;
      end
      DONE: begin
        gnt_d = 1'b1;
        if (we_q) wr_count_d = wr_count_q + 32'd1;
        else      rd_count_d = rd_count_q + 32'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      word_idx_q  <= '0;
      we_q        <= 1'b0;
      line_addr_q <= '0;
      wr_line_q   <= '0;
      rd_line_q   <= '0;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      word_idx_q  <= word_idx_d;
      we_q        <= we_d;
      line_addr_q <= line_addr_d;
      wr_line_q   <= wr_line_d;
      rd_line_q   <= rd_line_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Array is deliberately outside reset so an aborted writeback keeps its written words
  always_ff @(posedge clk) begin
    if (state_q == XFER && we_q) mem[mem_addr_c] <= wr_line_q[32*int'(word_idx_q) +: 32];
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign rd_line  = rd_line_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_line_port.sv
// Directed bench for mem_line_port: latency, burst data, isolation, input churn,
// held request and reset abort, all with hand-computed expectations.
module tb_mem_line_port;

  localparam int unsigned LA_W = 9;
  localparam int unsigned NW   = 8;
  localparam int unsigned LW   = 32 * NW;
  localparam int          GNT_EDGE = 13;

  logic            clk;
  logic            rst;
  logic            req;
  logic            we;
  logic [LA_W-1:0] line_addr;
  logic [LW-1:0]   wr_line;
  logic            gnt;
  logic [LW-1:0]   rd_line;
  logic            busy;
  logic [31:0]     rd_count;
  logic [31:0]     wr_count;

  int n_cmp = 0;
  int n_err = 0;

  mem_line_port #(.LINE_ADDR_LEN(3), .ADDR_LEN(12), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .line_addr(line_addr),
    .wr_line(wr_line), .gnt(gnt), .rd_line(rd_line), .busy(busy),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] ramp(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < NW; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [LW-1:0] fill(input logic [31:0] v);
    logic [LW-1:0] l;
    for (int i = 0; i < NW; i++) l[32*i +: 32] = v;
    return l;
  endfunction

  task automatic check_line(input string tag, input logic [LW-1:0] exp);
    for (int i = 0; i < NW; i++)
      check($sformatf("%s_w%0d", tag, i), 64'(rd_line[32*i +: 32]), 64'(exp[32*i +: 32]));
  endtask

  // One operation from an idle port: gnt must land on edge 13, busy high edges 0..13 only
  task automatic run_op(input string tag, input logic op_we, input logic [LA_W-1:0] a,
                        input logic [LW-1:0] d, input bit churn);
    int gnt_at;
    int n_gnt;
    int busy_bad;
    @(negedge clk);
    req = 1'b1; we = op_we; line_addr = a; wr_line = d;
    @(posedge clk); #1;
    check({tag, "_busy0"}, 64'(busy), 64'd1);
    gnt_at = -1; n_gnt = 0; busy_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (gnt) begin
        n_gnt++;
        if (gnt_at < 0) gnt_at = k;
      end
      if (gnt || k >= GNT_EDGE) req = 1'b0;
      if (busy !== ((k <= GNT_EDGE) ? 1'b1 : 1'b0)) busy_bad++;
      if (churn) begin
        line_addr = LA_W'($urandom);
        we = ~we;
        for (int i = 0; i < NW; i++) wr_line[32*i +: 32] = $urandom;
      end
    end
    check({tag, "_gnt_edge"}, 64'(gnt_at), 64'(GNT_EDGE));
    check({tag, "_gnt_cnt"}, 64'(n_gnt), 64'd1);
    check({tag, "_busy_win"}, 64'(busy_bad), 64'd0);
  endtask

  initial begin
    int g1;
    int g2;
    int n_gnt;
    rst = 1'b0; req = 1'b0; we = 1'b0; line_addr = '0; wr_line = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_gnt", 64'(gnt), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_rdline_zero", 64'(rd_line == '0), 64'd1);
      check("idle_rd_count", 64'(rd_count), 64'd0);
      check("idle_wr_count", 64'(wr_count), 64'd0);
    end

    // Write then read line 5
    run_op("wr5", 1'b1, LA_W'(5), ramp(32'hA000_0000), 1'b0);
    check("wr5_wr_count", 64'(wr_count), 64'd1);
    check("wr5_rdline_untouched", 64'(rd_line == '0), 64'd1);
    run_op("rd5", 1'b0, LA_W'(5), '0, 1'b0);
    check_line("rd5", ramp(32'hA000_0000));
    check("rd5_rd_count", 64'(rd_count), 64'd1);

    // Isolation
    run_op("wr6", 1'b1, LA_W'(6), fill(32'hFFFF_FFFF), 1'b0);
    run_op("rd5b", 1'b0, LA_W'(5), '0, 1'b0);
    check_line("rd5b", ramp(32'hA000_0000));
    run_op("rd7", 1'b0, LA_W'(7), '0, 1'b0);
    check_line("rd7", '0);
    check("iso_wr_count", 64'(wr_count), 64'd2);
    check("iso_rd_count", 64'(rd_count), 64'd3);

    // Input churn after acceptance
    run_op("wr8_churn", 1'b1, LA_W'(8), ramp(32'h5500_0000), 1'b1);
    check("churn_wr_count", 64'(wr_count), 64'd3);
    check("churn_rd_count", 64'(rd_count), 64'd3);
    run_op("rd8", 1'b0, LA_W'(8), '0, 1'b0);
    check_line("rd8", ramp(32'h5500_0000));
    run_op("rd6", 1'b0, LA_W'(6), '0, 1'b0);
    check_line("rd6", fill(32'hFFFF_FFFF));

    // Held req: write line 9, then a read of line 9 accepted on the first IDLE edge
    @(negedge clk);
    req = 1'b1; we = 1'b1; line_addr = LA_W'(9); wr_line = ramp(32'h9000_0000);
    @(posedge clk); #1;
    g1 = -1; g2 = -1; n_gnt = 0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (gnt) begin
        n_gnt++;
        if (g1 < 0) begin
          g1 = k;
          check("held_wr_count_at_gnt", 64'(wr_count), 64'd4);
          we = 1'b0;
        end else if (g2 < 0) g2 = k;
      end
      if (k == GNT_EDGE + 1) req = 1'b0;
    end
    check("held_gnt1_edge", 64'(g1), 64'(GNT_EDGE));
    check("held_gnt_spacing", 64'(g2 - g1), 64'd14);
    check("held_gnt_cnt", 64'(n_gnt), 64'd2);
    check("held_wr_count", 64'(wr_count), 64'd4);
    check("held_rd_count", 64'(rd_count), 64'd6);
    check_line("held_rd9", ramp(32'h9000_0000));
    check("held_busy_end", 64'(busy), 64'd0);

    // Reset abort in the third XFER cycle of a write to line 2
    @(negedge clk);
    req = 1'b1; we = 1'b1; line_addr = LA_W'(2); wr_line = ramp(32'h2200_0000);
    @(posedge clk); #1;
    req = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_gnt", 64'(gnt), 64'd0);
    check("abort_wr_count", 64'(wr_count), 64'd0);
    check("abort_rd_count", 64'(rd_count), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_gnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt) n_gnt++;
    end
    check("abort_no_gnt", 64'(n_gnt), 64'd0);
    run_op("rd2", 1'b0, LA_W'(2), '0, 1'b0);
    check_line("rd2", {{5{32'h0}}, 32'h2200_0002, 32'h2200_0001, 32'h2200_0000});
    check("rd2_rd_count", 64'(rd_count), 64'd1);
    check("rd2_wr_count", 64'(wr_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_line_port.md
Name: mem_line_port

Overview:
- Backing main-memory port behind the data cache in the WB stage.
- Serves whole-line refill reads and dirty-line writebacks through a req/gnt handshake.
- Models a fixed access latency followed by a one-word-per-cycle burst.
- The cache holds its miss signal high until gnt returns, so this block's timing directly sets the pipeline stall length.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; LINE_SIZE = 2^LINE_ADDR_LEN.
- ADDR_LEN, 12, log2 of memory depth in 32-bit words; line address width LA_W = ADDR_LEN-LINE_ADDR_LEN.
- LATENCY, 4, idle cycles between request acceptance and first burst word; 0 is legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req  in  1  request, level; held by cache until gnt.
- we  in  1  1 = line write (writeback), 0 = line read (refill).
- line_addr  in  LA_W  line address; word base = line_addr<<LINE_ADDR_LEN.
- wr_line  in  32*LINE_SIZE  write data; word i at bits [32*i+31:32*i].
- gnt  out  1  one-cycle completion pulse.
- rd_line  out  32*LINE_SIZE  read data; same word packing as wr_line.
- busy  out  1  high from acceptance until the gnt cycle, inclusive.
- rd_count  out  32  completed line reads.
- wr_count  out  32  completed line writes.

Behaviour:
- Reset (rst=0, async): state IDLE; gnt=0, busy=0, rd_line=0, rd_count=0, wr_count=0; internal counters cleared. Memory array is not cleared; simulation init is all-zero.
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - On an edge with req=1, latch we, line_addr and wr_line; set busy=1.
  - Next state is WAIT if LATENCY>0, else XFER.
  - Inputs are ignored after acceptance; changes mid-operation have no effect.
- WAIT: stays exactly LATENCY cycles (counter 0..LATENCY-1), then XFER.
- XFER: LINE_SIZE cycles, word index i = 0..LINE_SIZE-1, one word per cycle.
  - Write: mem[base+i] <= latched word i.
  - Read: rd_line word i <= mem[base+i].
  - After the last word, go to DONE.
- DONE: gnt=1 and busy=1 for exactly one cycle. Increment rd_count or wr_count by 1 (wraps at 2^32). Return to IDLE.
- gnt and busy are registered. busy drops to 0 in the cycle after gnt.
- Latency: with the accepting edge as edge 0, gnt is high during the cycle following edge LATENCY+LINE_SIZE+1. Defaults give edge 13.
- rd_line:
  - Valid in the gnt cycle; holds its value until the next read's XFER overwrites it.
  - Unchanged by write operations.
  - Partially updated while XFER is in progress.
- req still high in the DONE cycle is ignored. req still high on the first IDLE edge after DONE starts a new operation, so the cache must drop req in the gnt cycle.
- Back-to-back: minimum spacing between gnts is LATENCY+LINE_SIZE+2 cycles.
- Read after write to the same line returns the written data. Other lines are untouched.
- line_addr spans the full array; no wrap or out-of-range handling is needed.
- Reset mid-operation aborts immediately with no gnt. Words already written in XFER stay written; counters are cleared.
- No X propagation: all outputs are defined from reset.

Test Plan:
- Reset then idle: rst low 2 cycles, req=0 for 20 cycles -> gnt=0, busy=0, rd_line=0, counters 0 throughout.
- Write then read: write line 5 with word i = 32'hA000_0000+i -> gnt at edge 13 after acceptance, wr_count=1. Read line 5 -> rd_line word i = A000_0000+i, gnt at edge 13, rd_count=1, busy high for edges 1..13.
- Isolation: write line 6 with all words = 32'hFFFF_FFFF, then read lines 5 and 7 -> line 5 unchanged; line 7 all-zero.
- Input churn: after acceptance, toggle line_addr, we and wr_line every cycle -> result matches the latched request exactly; only one gnt.
- Held req: keep req=1 through gnt and one extra cycle -> a second operation is accepted on the first IDLE edge. gnt spacing is 14 cycles; counters increment once per gnt.
- Reset abort: assert rst at the 3rd XFER cycle of a write to line 2 -> no gnt, busy=0 immediately, wr_count=0. A subsequent read of line 2 returns words 0..2 new and words 3..7 old.
